serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Bit-serial two's-complement adder/subtractor. It computes one result bit per clock, LSB first, through a single one-bit add/sub cell with a registered carry. Operands load on a start pulse, and a one-cycle done pulse reports completion. It sits between the operand source (register file or switch latch) and the display/result register in the lab datapath, trading WIDTH cycles of latency for one cell of area.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
sub  input  1  mode latched with start: 0 = a+b, 1 = a-b
a  input  WIDTH  operand A, latched with start
b  input  WIDTH  operand B, latched with start
busy  output  1  high while bits are being computed
done  output  1  one-cycle pulse, result/cout/ovf valid from this cycle
result  output  WIDTH  sum or difference, held until next accepted start
cout  output  1  carry out of MSB; for sub, 1 = no borrow
ovf  output  1  signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on rst_n; clk is the only clock.
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, bit counter=0, operand shift regs=0, carry reg=0. An in-flight operation is abandoned; no done is produced for it.
- FSM states:
  - IDLE: waits for start.
  - RUN: computes bits.
  - DONE: single-cycle completion state.
- IDLE/DONE + start=1 -> RUN.
  - Load a and b into shift registers and latch sub.
  - carry reg := sub.
  - counter := 0; result := 0.
  - ovf/cout are not cleared until the new operation completes.
- RUN, each edge:
  - Cell inputs: ai=A[0], bi=B[0]^sub, ci=carry.
  - result shifts right with the sum bit entering at MSB; carry := cell cout.
  - A and B shift right; counter += 1.
- RUN at counter==WIDTH-1 (the MSB edge):
  - cout := cell cout.
  - ovf := ci ^ cell cout.
  - -> DONE.
- DONE: done=1 for exactly this cycle, then -> IDLE. A start in DONE is accepted (back-to-back ops, no dead cycle).
- Timing: start sampled at edge 0; busy=1 between edge 0 and edge WIDTH; done=1 between edge WIDTH and edge WIDTH+1.
- start while busy=1 is ignored. Inputs a/b/sub may change freely during RUN without affecting the result.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1; no wrap in normal flow.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1 via the inverted b and carry-in=sub.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the default WIDTH, and a clog2 constant function.
- One sub-module, addsub_bit (a, b, cin, sub -> sum, cout): a purely combinational full adder with b^sub on the b leg.
- serial_addsub holds the FSM, counter, shift registers and carry flop.

Test Plan (WIDTH=8):
1. a=0x35, b=0x4A, sub=0, start -> done at edge 8; result=0x7F, cout=0, ovf=0; busy high exactly 8 cycles.
2. a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0.
3. a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
4. Start a=0x05, b=0x03, sub=0. At edge 3 pulse start again with a=0xAA and change a/b -> second start ignored; result=0x08, single done pulse.
5. Start during the DONE cycle with a=0x02, b=0x02, sub=1 -> accepted; next done 9 edges after the first done; result=0x00, cout=1, ovf=0.
6. Assert rst_n=0 mid-RUN (edge 4) -> busy, done, result, cout, ovf all 0 immediately without a clock edge. No done follows. A fresh op after release completes normally.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Ceiling log2; used to size the bit counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_addsub_bit.sv
// One-bit add/sub cell: full adder with b inverted when sub=1.
module addsub_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic sum,
  output logic cout
);

  logic w_bx;

  // Pure combinational full adder on (a, b^sub, cin).
  always_comb begin
    w_bx = b ^ sub;
    sum  = a ^ w_bx ^ cin;
    cout = (a & w_bx) | (a & cin) | (w_bx & cin);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_sub;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
  logic               r_ovf;

  logic               w_sum;
  logic               w_cout;

  addsub_bit u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sub  (r_sub),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // FSM, operand shifters, carry flop and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_sub    <= sub;
            r_carry  <= sub;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_carry  <= w_cout;
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            // Counter holds at WIDTH-1; it is cleared on the next start.
            r_cout  <= w_cout;
            r_ovf   <= r_carry ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy   = r_busy;
    done   = r_done;
    result = r_result;
    cout   = r_cout;
    ovf    = r_ovf;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8), directed vectors.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  exp_t q[$];
  int   n_checks;
  int   n_fail;
  int   n_done;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops an expectation whenever done is presented.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_result", int'(result), int'(e.res));
          check("sb_cout", int'(cout), int'(e.c));
          check("sb_ovf", int'(ovf), int'(e.o));
        end
      end
    end
  endtask

  // Issue an op; returns #1 after the edge on which done rose.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vs, input logic [W-1:0] er,
                       input logic ec, input logic eo, input bit at_neg);
    exp_t e;
    int edges;
    int bcnt;
    if (at_neg) @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    e.res = er; e.c = ec; e.o = eo;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = ~va; b = ~vb; sub = ~vs;
    check("result_cleared_on_start", int'(result), 0);
    check("done_low_after_start", int'(done), 0);
    edges = 0; bcnt = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, W);
    check("busy_cycles", bcnt, W);
    check("busy_low_at_done", int'(busy), 0);
  endtask

  initial begin
    int edges;
    n_checks = 0; n_fail = 0; n_done = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk); rst_n = 1'b1;

    // 1-3: basic add/sub with carry/overflow corners
    do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("result_held", int'(result), 8'h7F);
    check("cout_held", int'(cout), 1);

    // 4: start while busy is ignored
    @(negedge clk);
    a = 8'h05; b = 8'h03; sub = 1'b0; start = 1'b1;
    q.push_back('{res: 8'h08, c: 1'b0, o: 1'b0});
    @(posedge clk); #1;
    start = 1'b0; a = 8'h99; b = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h3C;
    check("busy_during_ignored_start", int'(busy), 1);
    edges = 3;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ignored_start_latency", edges, W);

    // 5: back-to-back start in DONE cycle
    do_op(8'h02, 8'h02, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done_single_cycle", int'(done), 0);

    // 6: reset mid-run abandons the op
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_result", int'(result), 0);
    check("async_rst_cout", int'(cout), 0);
    check("async_rst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no_done_after_reset", int'(busy), 0);
    do_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    check("done_count", n_done, 8);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
